// File: rtl/equal_prec_meter_pkg.sv
// Shared definitions for the equal-precision frequency meter: FSM state codes,
// gate-select encodings and the saturating counter increment.
package meter_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StArm   = 3'd1;
    localparam logic [2:0] StMeas  = 3'd2;
    localparam logic [2:0] StClose = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [1:0] GATE_SEL_10MS  = 2'b00;
    localparam logic [1:0] GATE_SEL_100MS = 2'b01;
    localparam logic [1:0] GATE_SEL_1S    = 2'b10;

    // Counters narrower than 32 bits pass their own all-ones value as max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/equal_prec_meter_if.sv
// Control and result bundle of the frequency meter core.
interface equal_prec_meter_if #(
    parameter int unsigned NX_W = 32,
    parameter int unsigned NS_W = 32
);
    logic            F_in;
    logic            Run;
    logic [1:0]      Gate_sel;
    logic [NX_W-1:0] Nx_out;
    logic [NS_W-1:0] Ns_out;
    logic            Result_valid;
    logic            Over_alarm;
    logic            No_signal;
    logic            Gate_open;
    logic            Busy;

    modport master (
        output F_in, Run, Gate_sel,
        input  Nx_out, Ns_out, Result_valid, Over_alarm, No_signal, Gate_open, Busy
    );

    modport slave (
        input  F_in, Run, Gate_sel,
        output Nx_out, Ns_out, Result_valid, Over_alarm, No_signal, Gate_open, Busy
    );
endinterface

// File: rtl/equal_prec_meter_freq_in_sync.sv
// Two-flop synchroniser for the measured signal followed by a registered
// rising-edge detector producing a single-cycle pulse.
module freq_in_sync (
    input  logic Clock,
    input  logic Reset_n,
    input  logic F_in,
    output logic Edge
);

    // r_sync[1:0] is the synchroniser, r_sync[2] the previous synchronised level.
    logic [2:0] r_sync;
    logic       r_edge;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], F_in};
            r_edge <= r_sync[1] & ~r_sync[2];
        end
    end

    assign Edge = r_edge;

endmodule

// File: rtl/equal_prec_meter.sv
// Reciprocal frequency measurement: counts input periods (Nx) and reference cycles (Ns)
// over a gate that opens and closes on edges of the measured signal.
module equal_prec_meter
    import meter_pkg::*;
#(
    parameter int unsigned NX_W        = 32,
    parameter int unsigned NS_W        = 32,
    parameter int unsigned GATE_CYC0   = 500_000,
    parameter int unsigned GATE_CYC1   = 5_000_000,
    parameter int unsigned GATE_CYC2   = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic                Clock,
    input  logic                Reset_n,
    equal_prec_meter_if.slave   bus
);

    localparam logic [31:0] NX_MAX = 32'((64'd1 << NX_W) - 64'd1);
    localparam logic [31:0] NS_MAX = 32'((64'd1 << NS_W) - 64'd1);

    logic            w_edge;
    logic [2:0]      r_state, w_state_d;
    logic [NX_W-1:0] r_nx, w_nx_d, w_nx_inc;
    logic [NS_W-1:0] r_ns, w_ns_d, w_ns_inc;
    logic [31:0]     r_gate_cnt, w_gate_cnt_d;
    logic [31:0]     r_gate_len, w_gate_len_d, w_sel_len;
    logic [31:0]     r_to_cnt, w_to_cnt_d;
    logic            r_ovf, w_ovf_d, w_timeout;
    logic [NX_W-1:0] r_nx_out;
    logic [NS_W-1:0] r_ns_out;
    logic            r_valid, r_over, r_nosig;

    freq_in_sync u_sync (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .F_in    (bus.F_in),
        .Edge    (w_edge)
    );

    assign w_nx_inc = NX_W'(sat_inc(32'(r_nx), NX_MAX));
    assign w_ns_inc = NS_W'(sat_inc(32'(r_ns), NS_MAX));

    always_comb begin
        case (bus.Gate_sel)
            GATE_SEL_10MS:  w_sel_len = GATE_CYC0;
            GATE_SEL_100MS: w_sel_len = GATE_CYC1;
            default:        w_sel_len = GATE_CYC2;
        endcase
    end

    always_comb begin
        w_state_d    = r_state;
        w_nx_d       = r_nx;
        w_ns_d       = r_ns;
        w_gate_cnt_d = r_gate_cnt;
        w_gate_len_d = r_gate_len;
        w_to_cnt_d   = r_to_cnt;
        w_ovf_d      = r_ovf;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.Run) begin
                    w_state_d    = StArm;
                    w_gate_len_d = w_sel_len;
                    w_to_cnt_d   = '0;
                end
            end
            StArm: begin
                if (!bus.Run) begin
                    w_state_d = StIdle;
                end else if (w_edge) begin
                    w_state_d    = StMeas;
                    w_nx_d       = '0;
                    w_ns_d       = '0;
                    w_gate_cnt_d = '0;
                    w_ovf_d      = 1'b0;
                end else if (r_to_cnt == TIMEOUT_CYC) begin
                    w_state_d = StDone;
                    w_timeout = 1'b1;
                end else begin
                    w_to_cnt_d = r_to_cnt + 32'd1;
                end
            end
            StMeas: begin
                if (!bus.Run) begin
                    w_state_d = StIdle;
                end else begin
                    w_ns_d       = w_ns_inc;
                    w_ovf_d      = r_ovf | (&r_ns);
                    w_gate_cnt_d = r_gate_cnt + 32'd1;
                    if (w_edge) begin
                        w_nx_d  = w_nx_inc;
                        w_ovf_d = w_ovf_d | (&r_nx);
                    end
                    // An edge in the expiry cycle is counted but never closes the gate.
                    if (r_gate_cnt == r_gate_len - 32'd1) begin
                        w_state_d  = StClose;
                        w_to_cnt_d = '0;
                    end
                end
            end
            StClose: begin
                if (!bus.Run) begin
                    w_state_d = StIdle;
                end else begin
                    w_ns_d  = w_ns_inc;
                    w_ovf_d = r_ovf | (&r_ns);
                    if (w_edge) begin
                        w_nx_d    = w_nx_inc;
                        w_ovf_d   = w_ovf_d | (&r_nx);
                        w_state_d = StDone;
                    end else if (r_to_cnt == TIMEOUT_CYC) begin
                        w_state_d = StDone;
                        w_timeout = 1'b1;
                    end else begin
                        w_to_cnt_d = r_to_cnt + 32'd1;
                    end
                end
            end
            StDone: begin
                if (bus.Run) begin
                    w_state_d    = StArm;
                    w_gate_len_d = w_sel_len;
                    w_to_cnt_d   = '0;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= StIdle;
            r_nx       <= '0;
            r_ns       <= '0;
            r_gate_cnt <= '0;
            r_gate_len <= '0;
            r_to_cnt   <= '0;
            r_ovf      <= 1'b0;
            r_nx_out   <= '0;
            r_ns_out   <= '0;
            r_valid    <= 1'b0;
            r_over     <= 1'b0;
            r_nosig    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_nx       <= w_nx_d;
            r_ns       <= w_ns_d;
            r_gate_cnt <= w_gate_cnt_d;
            r_gate_len <= w_gate_len_d;
            r_to_cnt   <= w_to_cnt_d;
            r_ovf      <= w_ovf_d;
            r_valid    <= (w_state_d == StDone);
            // Results are loaded on the way into DONE so they appear with the valid pulse.
            if (w_state_d == StDone) begin
                r_nx_out <= w_timeout ? '0 : w_nx_d;
                r_ns_out <= w_timeout ? '0 : w_ns_d;
                r_over   <= w_ovf_d & ~w_timeout;
                r_nosig  <= w_timeout;
            end
        end
    end

    assign bus.Nx_out       = r_nx_out;
    assign bus.Ns_out       = r_ns_out;
    assign bus.Result_valid = r_valid;
    assign bus.Over_alarm   = r_over;
    assign bus.No_signal    = r_nosig;
    assign bus.Gate_open    = (r_state == StMeas) || (r_state == StClose);
    assign bus.Busy         = (r_state != StIdle);

endmodule

// File: doc/equal_prec_meter.md
# equal_prec_meter

Parametrised equal-precision (reciprocal) frequency measurement core. It replaces the fixed-gate direct counter and gate-control pair in the frequency meter. The measurement gate is synchronised to edges of the measured signal, so the result is an input-period count `Nx` and a reference-clock count `Ns` over the same interval. Downstream logic computes f = Nx·CLK_HZ/Ns, which has equal relative precision across the range. The core sits between the board input pin and the divider/latch/display path.

## Interface
- `NX_W`, 32: width of the input-edge counter and `Nx_out`.
- `NS_W`, 32: width of the reference-cycle counter and `Ns_out`.
- `GATE_CYC0`, 500_000: preset gate for `Gate_sel`=00 (10 ms at 50 MHz).
- `GATE_CYC1`, 5_000_000: preset gate for `Gate_sel`=01 (100 ms).
- `GATE_CYC2`, 50_000_000: preset gate for `Gate_sel`=10 or 11 (1 s).
- `TIMEOUT_CYC`, 100_000_000: maximum cycles spent waiting for an edge in ARM or CLOSE.

Ports:
- `Clock` in 1: single system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `F_in` in 1: measured signal. It is asynchronous to `Clock`.
- `Run` in 1: level. 1 = measure continuously; 0 = idle or abort.
- `Gate_sel` in 2: preset gate select. Sampled only on entry to ARM.
- `Nx_out` out NX_W: latched count of input periods.
- `Ns_out` out NS_W: latched count of reference cycles.
- `Result_valid` out 1: one-cycle pulse when `Nx_out`, `Ns_out` and the flags update.
- `Over_alarm` out 1: latched with each result. 1 = a counter saturated.
- `No_signal` out 1: latched with each result. 1 = the measurement timed out.
- `Gate_open` out 1: high in MEAS and CLOSE.
- `Busy` out 1: high in any state except IDLE.

## Operation
- `F_in` passes through a 2-FF synchroniser and a rising-edge detector, producing `edge`, a one-cycle pulse.
- FSM states: IDLE, ARM, MEAS, CLOSE, DONE.
- IDLE:
  - When `Run`=1, go to ARM.
  - On the IDLE→ARM or DONE→ARM transition, latch `Gate_sel` into the preset-gate length and clear the timeout counter.
- ARM:
  - On `edge`, clear `Nx` and `Ns` to 0, clear the gate counter, and go to MEAS. The opening edge is not counted.
- MEAS:
  - `Ns` increments every cycle.
  - `Nx` increments on each `edge`.
  - The gate counter increments every cycle. After GATE_CYC cycles in MEAS, go to CLOSE.
  - An `edge` in the expiry cycle is counted and does not close the gate.
- CLOSE:
  - `Ns` increments every cycle and `Nx` increments on `edge`.
  - The first `edge` in CLOSE is counted and closes the gate: go to DONE.
- DONE:
  - Copy the counters to the outputs.
  - Pulse `Result_valid`.
  - Go to ARM if `Run`=1, else IDLE.
- Timeout:
  - The timeout counter runs in ARM and CLOSE. It is cleared on entry to ARM and on the MEAS→CLOSE transition.
  - On reaching TIMEOUT_CYC, go to DONE with `No_signal`=1, `Nx_out`=0 and `Ns_out`=0.
- Saturation: `Nx` and `Ns` hold at all-ones instead of wrapping. A sticky overflow bit is set and is reported as `Over_alarm` in DONE.
- Abort: `Run`=0 in ARM, MEAS or CLOSE goes to IDLE next cycle. There is no `Result_valid`, and the outputs keep the previous result.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - The synchroniser flops and the internal counters are 0.
- `edge` occurs 3 `Clock` cycles after a rising edge of `F_in`. The detector reports at most one pulse per cycle.
- `Ns` equals the number of cycles from the cycle after the opening `edge` up to and including the closing `edge`.
- `Result_valid` asserts exactly 1 cycle after the closing `edge`. The outputs are valid in the same cycle and hold until the next DONE.
- Back-to-back measurements: the next ARM begins the cycle after DONE. An `edge` occurring during DONE is ignored.
- Reset mid-operation: the core returns immediately to reset values and the partial result is discarded.

## Structure
- Package `meter_pkg` holds:
  - the state enum;
  - the `Gate_sel` encoding constants;
  - the saturating-increment helper function.
- Sub-module `freq_in_sync` holds the 2-FF synchroniser plus the rising-edge detector. Its ports are `Clock`, `Reset_n`, `F_in` and `edge`.
- The FSM, counters and output registers stay in `equal_prec_meter`.

## Test plan
- Period-10 input, GATE_CYC0=100, `Gate_sel`=00, `Run`=1 → `Nx_out`=11, `Ns_out`=110, `Over_alarm`=0, `No_signal`=0. `Result_valid` fires 1 cycle after the closing edge.
- `F_in` stuck low, TIMEOUT_CYC=50 → `Result_valid` 51 cycles after ARM entry, with `No_signal`=1 and `Nx_out`=`Ns_out`=0.
- NS_W=8, GATE_CYC0=300, period-7 input → `Ns_out`=255, `Over_alarm`=1, and `Nx_out` is correct with no wrap.
- `Run` dropped mid-MEAS → `Busy`=0 the next cycle, no `Result_valid`, and the previous outputs are unchanged.
- `Gate_sel` changed from 00 to 01 during MEAS → the current result uses GATE_CYC0 and the next result uses GATE_CYC1.
- `Reset_n` asserted asynchronously in CLOSE → all outputs are 0 immediately. After release with `Run`=1, a full valid measurement follows.
